// File: rtl/generador_mdio_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : generador_mdio_if                                         |
// | Brief    : Host request, PHY line and status bundle for generador_mdio|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface generador_mdio_if;
  logic [31:0] t_data;
  logic        t_data_valid;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;
  logic        err;

  modport master (
    output t_data, t_data_valid, mdio_in,
    input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, err
  );

  modport slave (
    input  t_data, t_data_valid, mdio_in,
    output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/generador_mdio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : generador_mdio                                            |
// | Brief    : MDIO management-side frame serializer / read collector.   |
// |            Optional start-field check: MDIO_CHECK_START_EN.          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module generador_mdio #(
  parameter int MDC_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  generador_mdio_if.slave   mgmt
);

  localparam int                   c_div_w   = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [c_div_w-1:0]   c_div_max = c_div_w'(MDC_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENVIAR  = 2'd1,
    RECIBIR = 2'd2,
    PAUSA   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic               mdc_q, mdc_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [31:0]        sr_q, sr_d;
  logic [15:0]        rx_q, rx_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               data_rdy_q, data_rdy_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               out_q, out_d;
  logic               oe_q, oe_d;

  logic               w_tick;
  logic               w_fall;
  logic               w_rd;
  logic               w_start_ok;

  assign w_tick = (div_q == c_div_max);
  assign w_fall = w_tick & mdc_q;
  assign w_rd   = (sr_q[29:28] == 2'b10);

`ifdef MDIO_CHECK_START_EN
  assign w_start_ok = (mgmt.t_data[31:30] == 2'b01);
`else
  assign w_start_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      mdc_q      <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      data_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      mdc_q      <= mdc_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      data_rdy_q <= data_rdy_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = w_tick ? '0 : div_q + 1'b1;
    mdc_d      = w_tick ? ~mdc_q : mdc_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    data_rdy_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    out_d      = out_q;
    oe_d       = oe_q;

    case (state_q)
      IDLE: begin
        if (mgmt.t_data_valid) begin
          if (w_start_ok) begin
            sr_d    = mgmt.t_data;
            cnt_d   = 6'd31;
            busy_d  = 1'b1;
            state_d = ENVIAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ENVIAR: begin
        // cnt_q counts bits still to present; it underflows to 6'h3F after bit 0
        if (w_fall) begin
          if (oe_q && w_rd && (cnt_q == 6'd15)) begin
            state_d = RECIBIR;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q[5]) begin
            state_d = PAUSA;
            oe_d    = 1'b0;
            out_d   = 1'b0;
          end else begin
            out_d = sr_q[cnt_q[4:0]];
            oe_d  = 1'b1;
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      RECIBIR: begin
        if (w_fall) begin
          rx_d  = {mgmt.mdio_in, rx_q[15:1]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            rd_data_d  = {mgmt.mdio_in, rx_q[15:1]};
            data_rdy_d = 1'b1;
            state_d    = PAUSA;
          end
        end
      end

      PAUSA: begin
        if (w_fall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mgmt.mdc      = mdc_q;
  assign mgmt.mdio_out = out_q;
  assign mgmt.mdio_oe  = oe_q;
  assign mgmt.rd_data  = rd_data_q;
  assign mgmt.data_rdy = data_rdy_q;
  assign mgmt.busy     = busy_q;
  assign mgmt.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_generador_mdio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_generador_mdio                                         |
// | Brief    : Scoreboard bench for generador_mdio with a PHY-side model.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_generador_mdio;

  localparam int DIV = 1;
  localparam int BIT = 2 * DIV;
`ifdef MDIO_CHECK_START_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  generador_mdio_if bus ();

  generador_mdio #(.MDC_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .mgmt  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] bits;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] rd_q[$];
  int          err_exp = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic [15:0] phy_word = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_mdc"},      32'(bus.mdc),      0);
    chk({tag, "_mdio_out"}, 32'(bus.mdio_out), 0);
    chk({tag, "_mdio_oe"},  32'(bus.mdio_oe),  0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),  0);
    chk({tag, "_data_rdy"}, 32'(bus.data_rdy), 0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk({tag, "_err"},      32'(bus.err),      0);
  endtask

  // Monitor: the line as a PHY sees it on mdc rising edges, plus status pulses.
  initial begin
    int          nb;
    logic [31:0] bits;
    logic        pm;
    int          since;
    bit          seen;
    frame_t      e;
    logic [15:0] w;
    nb = 0; bits = '0; pm = 1'b0; since = 0; seen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        rd_q.delete();
        err_exp = 0;
        nb = 0; bits = '0; pm = 1'b0; since = 0; seen = 1'b0;
        continue;
      end
      since++;
      if (bus.mdc != pm) begin
        if (seen) chk("mdc_half_period", 32'(since), 32'(DIV));
        seen  = 1'b1;
        since = 0;
      end
      if (bus.mdc && !pm) begin
        if (bus.mdio_oe) begin
          bits = {bits[30:0], bus.mdio_out};
          nb++;
        end else if (nb > 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_bits", 32'(nb), 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bit_count", 32'(nb), 32'(e.n));
            chk("frame_bits", bits, e.bits);
          end
          nb = 0; bits = '0;
        end
      end
      pm = bus.mdc;
      if (bus.data_rdy) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_data_rdy", 32'(bus.data_rdy), 0);
        end else begin
          w = rd_q.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(w));
        end
      end
      if (bus.err) begin
        chk("unexpected_err", 32'(err_exp > 0), 1);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  // PHY model: after a 16-bit driven preamble, returns phy_word LSB first,
  // changing the line on each mdc rising edge.
  initial begin
    int   phy_n;
    int   rx_i;
    bit   rx_on;
    logic pm;
    phy_n = 0; rx_i = 0; rx_on = 1'b0; pm = 1'b0;
    bus.mdio_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (reset) begin
        phy_n = 0; rx_on = 1'b0; pm = 1'b0; bus.mdio_in = 1'b0;
        continue;
      end
      if (bus.mdc && !pm) begin
        if (rx_on) begin
          bus.mdio_in = phy_word[rx_i];
          rx_i++;
          if (rx_i == 16) rx_on = 1'b0;
        end else if (bus.mdio_oe) begin
          phy_n++;
        end else begin
          if (phy_n == 16) begin
            bus.mdio_in = phy_word[0];
            rx_i  = 1;
            rx_on = 1'b1;
          end
          phy_n = 0;
        end
      end
      pm = bus.mdc;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 300) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_wait", 32'(bus.busy), 0);
  endtask

  task automatic send(input logic [31:0] f, input logic [15:0] rdw, input bit inject);
    int k;
    bit ok;
    wait_idle();
    ok = !CHK || (f[31:30] == 2'b01);
    if (ok) begin
      if (f[29:28] == 2'b10) begin
        phy_word = rdw;
        rd_q.push_back(rdw);
        exp_q.push_back('{n: 16, bits: {16'h0, f[31:16]}});
      end else begin
        exp_q.push_back('{n: 32, bits: f});
      end
    end else begin
      err_exp++;
    end
    bus.t_data       = f;
    bus.t_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.t_data_valid = 1'b0;
    chk("busy_after_capture", 32'(bus.busy), 32'(ok));
    if (!ok) begin
      chk("err_pulse", 32'(bus.err), 1);
      @(posedge clk); #1;
      chk("err_width", 32'(bus.err), 0);
      chk("oe_bad_start", 32'(bus.mdio_oe), 0);
      chk("busy_bad_start", 32'(bus.busy), 0);
      return;
    end
    k = 0;
    while (!bus.mdio_oe && k < 4 * BIT) begin
      @(posedge clk); #1; k++;
    end
    chk("first_bit_latency", 32'(k >= 1 && k <= BIT), 1);
    k = 0;
    while (bus.busy && k < 40 * BIT) begin
      if (inject && k == 20 * BIT) begin
        bus.t_data       = 32'h50000000;
        bus.t_data_valid = 1'b1;
      end else begin
        bus.t_data_valid = 1'b0;
      end
      @(posedge clk); #1; k++;
    end
    bus.t_data_valid = 1'b0;
    chk("busy_length", 32'(k), 32'(33 * BIT));
  endtask

  task automatic reset_mid_read();
    int   n;
    int   k;
    logic pm;
    wait_idle();
    phy_word         = 16'h1357;
    bus.t_data       = 32'h6A2C0000;
    bus.t_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.t_data_valid = 1'b0;
    pm = bus.mdc; n = 0; k = 0;
    while (n < 10 && k < 200) begin
      @(posedge clk); #1; k++;
      if (bus.mdc && !pm && bus.mdio_oe) n++;
      pm = bus.mdc;
    end
    chk("reach_read_bit10", 32'(n), 10);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("reset_mid_frame");
    reset = 1'b0;
  endtask

  initial begin
    bus.t_data       = '0;
    bus.t_data_valid = 1'b0;
    reset            = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero_outputs("reset");
    end
    reset = 1'b0;

    send(32'h5A5A1234, 16'h0000, 1'b0);
    send(32'h6A2C0000, 16'hBEEF, 1'b1);
    chk("rd_data_held", 32'(bus.rd_data), 32'hBEEF);
    reset_mid_read();
    send(32'h5A5A1234, 16'h0000, 1'b0);
    send(32'hE0000000, 16'hC0DE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] f;
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[31:30] = 2'b01;
      send(f, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (4 * BIT) @(posedge clk);
    #1;
    chk("frames_outstanding", 32'(exp_q.size()), 0);
    chk("reads_outstanding", 32'(rd_q.size()), 0);
    chk("errs_outstanding", 32'(err_exp), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
